stream_slave_upsample_mc: RTL and testbench

Multi-channel AXI4-Stream slave that feeds the FIR datapath. It upsamples each accepted input beat by run-time rate R: one sample beat, then R inserted beats. After TLAST it appends a run-time number of tail (flush) beats. The output is a registered valid/ready stream toward the FIR core, with true backpressure and a beat-aligned packet-end flag. It supersedes the single-channel, non-stallable rate front end.

---
 rtl/stream_slave_upsample_mc.sv | 129 ++++++++++++
 tb/tb_stream_slave_upsample_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_slave_upsample_mc.sv
// stream_slave_upsample_mc: multi-channel AXI4-Stream upsampler with zero/hold insertion and tail flush; FIR_UPS_HOLD_EN enables zero-order hold
module stream_slave_upsample_mc #(
  parameter int DATA_W = 16,
  parameter int CH = 2,
  parameter int RATE_W = 4,
  parameter int TAIL_W = 8
) (
  input  logic                     S_AXIS_ACLK,
  input  logic                     S_AXIS_ARESET,
  input  logic [CH*DATA_W-1:0]     S_AXIS_TDATA,
  input  logic [CH*DATA_W/8-1:0]   S_AXIS_TSTRB,
  input  logic                     S_AXIS_TLAST,
  input  logic                     S_AXIS_TVALID,
  output logic                     S_AXIS_TREADY,
  input  logic [RATE_W-1:0]        rate,
  input  logic [TAIL_W-1:0]        tail,
  input  logic                     hold_mode,
  output logic [CH*DATA_W-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy
);
  localparam int W = CH*DATA_W;
  typedef enum logic [1:0] {VALUE, ZERO, LAST_ZERO, TAIL} state_t;
  state_t state_q, state_d;
  logic [RATE_W-1:0] cnt_q, cnt_d, rate_q, rate_d, rate_e;
  logic [TAIL_W-1:0] tcnt_q, tcnt_d, tail_q, tail_d, tail_e;
  logic [W-1:0] out_data_q, out_data_d, ins;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, first_q, first_d;
  logic adv, acc, unused_ok;
  assign adv = !out_valid_q || out_ready;
  assign S_AXIS_TREADY = (state_q == VALUE) && adv && !S_AXIS_ARESET;
  assign acc = S_AXIS_TVALID && S_AXIS_TREADY;
  assign rate_e = first_q ? rate : rate_q;
  assign tail_e = first_q ? tail : tail_q;
  assign busy = state_q != VALUE;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last = out_last_q;
  assign unused_ok = ^{S_AXIS_TSTRB, hold_mode};
`ifdef FIR_UPS_HOLD_EN
  logic [W-1:0] hold_q, hold_d;
  assign ins = hold_mode ? hold_q : '0;
  // remember the last accepted sample for zero-order hold
  always_comb hold_d = acc ? S_AXIS_TDATA : hold_q;
  // hold register
  always_ff @(posedge S_AXIS_ACLK) hold_q <= S_AXIS_ARESET ? '0 : hold_d;
`else
  assign ins = '0;
`endif
  // next state, counters and output register contents; everything advances only on adv
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tcnt_d = tcnt_q;
    rate_d = rate_q;
    tail_d = tail_q;
    first_d = first_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d = out_last_q;
    if (adv) begin
      out_valid_d = 1'b1;
      out_last_d = 1'b0;
      case (state_q)
        VALUE: begin
          out_valid_d = acc;
          if (acc) begin
            out_data_d = S_AXIS_TDATA;
            rate_d = rate_e;
            tail_d = tail_e;
            first_d = S_AXIS_TLAST;
            if (rate_e != '0) begin
              state_d = S_AXIS_TLAST ? LAST_ZERO : ZERO;
              cnt_d = RATE_W'(1);
            end else if (S_AXIS_TLAST && tail_e != '0) begin
              state_d = TAIL;
              tcnt_d = TAIL_W'(1);
            end else out_last_d = S_AXIS_TLAST;
          end
        end
        ZERO, LAST_ZERO: begin
          out_data_d = ins;
          cnt_d = cnt_q + RATE_W'(1);
          if (cnt_q == rate_q) begin
            cnt_d = '0;
            state_d = (state_q == ZERO || tail_q == '0) ? VALUE : TAIL;
            tcnt_d = (state_q == LAST_ZERO && tail_q != '0) ? TAIL_W'(1) : tcnt_q;
            out_last_d = state_q == LAST_ZERO && tail_q == '0;
          end
        end
        default: begin
          out_data_d = '0;
          tcnt_d = tcnt_q + TAIL_W'(1);
          if (tcnt_q == tail_q) begin
            out_last_d = 1'b1;
            state_d = VALUE;
            tcnt_d = '0;
          end
        end
      endcase
    end
  end
  // state and output registers with synchronous reset
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q <= VALUE;
      cnt_q <= '0;
      tcnt_q <= '0;
      rate_q <= '0;
      tail_q <= '0;
      first_q <= 1'b1;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tcnt_q <= tcnt_d;
      rate_q <= rate_d;
      tail_q <= tail_d;
      first_q <= first_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
    end
  end
endmodule

// File: tb/tb_stream_slave_upsample_mc.sv
// tb_stream_slave_upsample_mc: randomized self-checking bench against a packet-level reference model
module tb_stream_slave_upsample_mc;
  localparam int DW = 16, CH = 2, RW = 4, TW = 8, W = DW*CH;
`ifdef FIR_UPS_HOLD_EN
  localparam bit HOLD_BUILT = 1'b1;
`else
  localparam bit HOLD_BUILT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] tdata = '0;
  logic [W/8-1:0] tstrb = '0;
  logic tlast = 1'b0, tvalid = 1'b0, tready;
  logic [RW-1:0] rate = '0;
  logic [TW-1:0] tail = '0;
  logic hold_mode = 1'b0;
  logic [W-1:0] out_data;
  logic out_valid, out_ready = 1'b1, out_last, busy;
  int checks = 0, errors = 0, stall_viol = 0;
  bit bp = 1'b0;
  logic [W-1:0] tx[$], exp_d[$], got_d[$];
  bit exp_l[$], got_l[$];
  logic [W-1:0] prev_d = '0;
  logic prev_v = 1'b0, prev_l = 1'b0, prev_stall = 1'b0;

  always #5 clk = ~clk;

  stream_slave_upsample_mc dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb),
    .S_AXIS_TLAST(tlast), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
    .rate(rate), .tail(tail), .hold_mode(hold_mode),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  initial forever begin
    @(posedge clk);
    #1 out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // collect output handshakes and note any stall-rule breakage
  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall && (out_data !== prev_d || out_valid !== prev_v || out_last !== prev_l)) stall_viol++;
      if (out_valid && !out_ready && tready) stall_viol++;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_v = out_valid;
      prev_l = out_last;
    end
  end

  // each sample becomes itself plus r inserted beats, then t zero beats; only the final beat is last
  function automatic void model(input int r, input int t, input bit h);
    foreach (tx[i]) begin
      exp_d.push_back(tx[i]);
      for (int k = 0; k < r; k++) exp_d.push_back(h ? tx[i] : '0);
    end
    for (int k = 0; k < t; k++) exp_d.push_back('0);
    foreach (exp_d[i]) exp_l.push_back(i == exp_d.size() - 1);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", out_last); end
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b exp 0", tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 1'b0;
    #1;
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL release_tready got %b exp 1", tready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream(input string name, input int r, input int t, input bit h,
                             input bit b, input bit gaps, input int new_r);
    int budget;
    bit a;
    bp = b;
    rate = RW'(r);
    tail = TW'(t);
    hold_mode = h;
    exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
    stall_viol = 0;
    model(r, t, h && HOLD_BUILT);
    foreach (tx[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      tvalid = 1'b1;
      tdata = tx[i];
      tlast = (i == tx.size() - 1);
      budget = 0;
      while (1) begin
        @(negedge clk);
        a = tready;
        @(posedge clk);
        #1;
        if (a) break;
        if (++budget > 300) begin
          checks++; errors++;
          $display("FAIL %s accept_timeout beat %0d", name, i);
          break;
        end
      end
      tvalid = 1'b0;
      tlast = 1'b0;
      checks++;
      if (a && (out_valid !== 1'b1 || out_data !== tx[i])) begin
        errors++;
        $display("FAIL %s latency beat %0d got %b/%h exp 1/%h", name, i, out_valid, out_data, tx[i]);
      end
      if (i == 0 && new_r >= 0) rate = RW'(new_r);
    end
    budget = 0;
    while (got_d.size() < exp_d.size() && budget < 3000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL %s beat_count got %0d exp %0d", name, got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL %s beat %0d got %h/%b exp %h/%b", name, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL %s stall_rule got %0d violations exp 0", name, stall_viol);
    end
    bp = 1'b0;
  endtask

  task automatic test_passthrough();
    tx = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008};
    test_stream("passthrough", 0, 0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_zero_insert();
    tx = '{32'hAAAA_1111, 32'hBBBB_2222, 32'hCCCC_3333};
    test_stream("zero_insert", 3, 5, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    tx = '{32'hAAAA_1111, 32'hBBBB_2222, 32'hCCCC_3333};
    test_stream("backpressure", 3, 5, 1'b0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_config_change();
    tx = '{32'h1234_0001, 32'h1234_0002, 32'h1234_0003};
    test_stream("cfg_first_pkt", 3, 0, 1'b0, 1'b0, 1'b0, 1);
    tx = '{32'h5678_0001, 32'h5678_0002};
    test_stream("cfg_next_pkt", 1, 0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_hold();
    tx = '{32'h0000_0005, 32'h0000_0009};
    test_stream("hold", 2, 2, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    bp = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rate = '0;
    tail = TW'(20);
    tvalid = 1'b1;
    tdata = 32'hDEAD_BEEF;
    tlast = 1'b1;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_in_tail got %b exp 1", busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", busy); end
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL mid_reset_tready got %b exp 0", tready); end
    rst = 1'b0;
    #1;
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL mid_release_tready got %b exp 1", tready); end
    @(posedge clk);
    #1;
    tx = '{32'h0BAD_F00D, 32'h0000_0001};
    test_stream("after_reset", 1, 2, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_boundary();
    tx = '{32'hFFFF_0001, 32'h0001_FFFF};
    test_stream("max_rate_tail", 15, 255, 1'b0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      tx.delete();
      repeat ($urandom_range(1, 4)) tx.push_back($urandom);
      test_stream($sformatf("random%0d", p), $urandom_range(0, 3), $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_zero_insert();
    test_backpressure();
    test_config_change();
    test_hold();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
